vend_txn_ctrl: RTL and testbench



---
 rtl/vend_txn_ctrl_if.sv | 31 +++
 rtl/vend_txn_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_vend_txn_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/vend_txn_ctrl_if.sv
// Event and output bundle between the vending front end and the transaction sequencer.
interface vend_txn_ctrl_if;
  logic       tick;
  logic       coin_in;
  logic [1:0] coin_val;
  logic       sel_juice;
  logic       sel_coffee;
  logic       cancel;
  logic       drop_juice;
  logic       drop_coffee;
  logic       coin_out;
  logic       coin_reject;
  logic       busy;
  logic [6:0] credit;
  logic [3:0] BCD3;
  logic [3:0] BCD2;
  logic [3:0] BCD1;
  logic [3:0] BCD0;

  modport master (
    output tick, coin_in, coin_val, sel_juice, sel_coffee, cancel,
    input  drop_juice, drop_coffee, coin_out, coin_reject, busy, credit,
           BCD3, BCD2, BCD1, BCD0
  );

  modport slave (
    input  tick, coin_in, coin_val, sel_juice, sel_coffee, cancel,
    output drop_juice, drop_coffee, coin_out, coin_reject, busy, credit,
           BCD3, BCD2, BCD1, BCD0
  );
endinterface

// File: rtl/vend_txn_ctrl.sv
// Vending transaction sequencer: credit tracking, selection/vend, change payout
// and display digit generation. All outputs are registered.
module vend_txn_ctrl #(
  parameter int unsigned PRICE_JUICE  = 25,
  parameter int unsigned PRICE_COFFEE = 20,
  parameter int unsigned MAX_CREDIT   = 100,
  parameter int unsigned SHOW_TICKS   = 3,
  parameter int unsigned ERR_TICKS    = 2
) (
  input  logic          clk,
  input  logic          rst,
  vend_txn_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_SHOW    = 2'd2,
    ST_CHANGE  = 2'd3
  } state_t;

  typedef enum logic {
    ITEM_JUICE  = 1'b0,
    ITEM_COFFEE = 1'b1
  } item_t;

  localparam logic [6:0] P_JUICE   = 7'(PRICE_JUICE);
  localparam logic [6:0] P_COFFEE  = 7'(PRICE_COFFEE);
  localparam logic [7:0] P_MAX     = 8'(MAX_CREDIT);
  localparam logic [7:0] SHOW_LAST = 8'(SHOW_TICKS - 1);
  localparam logic [7:0] ERR_LAST  = 8'(ERR_TICKS - 1);

  state_t     r_state;
  item_t      r_item;
  logic [6:0] r_credit;
  logic       r_err;
  logic [6:0] r_err_price;
  logic [7:0] r_tick_cnt;
  logic       r_drop_juice;
  logic       r_drop_coffee;
  logic       r_coin_out;
  logic       r_coin_reject;
  logic       r_busy;
  logic [3:0] r_bcd3;
  logic [3:0] r_bcd2;
  logic [3:0] r_bcd1;
  logic [3:0] r_bcd0;

  logic [6:0] w_coin_amt;
  logic       w_coin_vld;
  logic [7:0] w_sum;
  logic       w_coin_ok;
  logic       w_sel;
  item_t      w_sel_item;
  logic [6:0] w_price;
  logic       w_afford;
  logic       w_cancel_act;

  // Three BCD digits of a 0..127 value.
  function automatic logic [11:0] f_bcd(input logic [6:0] v);
    logic [6:0] rem;
    rem = v % 7'd100;
    return {4'(v / 7'd100), 4'(rem / 7'd10), 4'(rem % 7'd10)};
  endfunction

  // Decode coin value, selection and acceptance conditions.
  always_comb begin
    w_coin_amt = '0;
    w_coin_vld = 1'b0;
    case (bus.coin_val)
      2'b00:   begin w_coin_amt = 7'd5;  w_coin_vld = bus.coin_in; end
      2'b01:   begin w_coin_amt = 7'd10; w_coin_vld = bus.coin_in; end
      2'b10:   begin w_coin_amt = 7'd50; w_coin_vld = bus.coin_in; end
      default: begin w_coin_amt = '0;    w_coin_vld = 1'b0;        end
    endcase
    w_sum        = {1'b0, r_credit} + {1'b0, w_coin_amt};
    w_coin_ok    = w_coin_vld && (w_sum <= P_MAX);
    w_sel        = bus.sel_juice | bus.sel_coffee;
    w_sel_item   = bus.sel_juice ? ITEM_JUICE : ITEM_COFFEE;
    w_price      = bus.sel_juice ? P_JUICE : P_COFFEE;
    w_afford     = (r_credit >= w_price);
    // Cancel only pre-empts lower-priority events when it actually takes effect.
    w_cancel_act = bus.cancel && (r_state == ST_COLLECT);
  end

  // Transaction FSM with registered strobes, credit and busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_item        <= ITEM_JUICE;
      r_credit      <= '0;
      r_err         <= 1'b0;
      r_err_price   <= '0;
      r_tick_cnt    <= '0;
      r_drop_juice  <= 1'b0;
      r_drop_coffee <= 1'b0;
      r_coin_out    <= 1'b0;
      r_coin_reject <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_drop_juice  <= 1'b0;
      r_drop_coffee <= 1'b0;
      r_coin_out    <= 1'b0;
      r_coin_reject <= 1'b0;
      case (r_state)
        ST_IDLE, ST_COLLECT: begin
          if (w_cancel_act) begin
            r_state       <= ST_CHANGE;
            r_busy        <= 1'b1;
            r_err         <= 1'b0;
            r_tick_cnt    <= '0;
            r_coin_reject <= bus.coin_in;
          end else if (w_sel) begin
            r_coin_reject <= bus.coin_in;
            r_tick_cnt    <= '0;
            if (w_afford) begin
              r_drop_juice  <= (w_sel_item == ITEM_JUICE);
              r_drop_coffee <= (w_sel_item == ITEM_COFFEE);
              r_credit      <= r_credit - w_price;
              r_item        <= w_sel_item;
              r_state       <= ST_SHOW;
              r_busy        <= 1'b1;
              r_err         <= 1'b0;
            end else begin
              r_err       <= 1'b1;
              r_err_price <= w_price;
            end
          end else if (w_coin_ok) begin
            r_credit <= w_sum[6:0];
            r_state  <= ST_COLLECT;
            r_err    <= 1'b0;
          end else begin
            r_coin_reject <= bus.coin_in;
            // Error display times out on ticks even if a coin was rejected.
            if (r_err && bus.tick) begin
              if (r_tick_cnt == ERR_LAST) begin
                r_err      <= 1'b0;
                r_tick_cnt <= '0;
              end else begin
                r_tick_cnt <= r_tick_cnt + 8'd1;
              end
            end
          end
        end
        ST_SHOW: begin
          r_coin_reject <= bus.coin_in;
          if (bus.tick) begin
            if (r_tick_cnt == SHOW_LAST) begin
              r_tick_cnt <= '0;
              if (r_credit != '0) begin
                r_state <= ST_CHANGE;
              end else begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 8'd1;
            end
          end
        end
        ST_CHANGE: begin
          r_coin_reject <= bus.coin_in;
          if (bus.tick) begin
            r_coin_out <= 1'b1;
            r_credit   <= r_credit - 7'd5;
            if (r_credit == 7'd5) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Display digits derived from the registered transaction state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {r_bcd3, r_bcd2, r_bcd1, r_bcd0} <= {4'd15, 4'd0, 4'd0, 4'd0};
    end else if (r_state == ST_SHOW) begin
      if (r_item == ITEM_JUICE)
        {r_bcd3, r_bcd2, r_bcd1, r_bcd0} <= {4'd10, 4'd11, 4'd12, 4'd13};
      else
        {r_bcd3, r_bcd2, r_bcd1, r_bcd0} <= {4'd13, 4'd0, 4'd14, 4'd14};
    end else if (r_err) begin
      {r_bcd3, r_bcd2, r_bcd1, r_bcd0} <= {4'd15, f_bcd(r_err_price)};
    end else begin
      {r_bcd3, r_bcd2, r_bcd1, r_bcd0} <= {4'd15, f_bcd(r_credit)};
    end
  end

  assign bus.drop_juice  = r_drop_juice;
  assign bus.drop_coffee = r_drop_coffee;
  assign bus.coin_out    = r_coin_out;
  assign bus.coin_reject = r_coin_reject;
  assign bus.busy        = r_busy;
  assign bus.credit      = r_credit;
  assign bus.BCD3        = r_bcd3;
  assign bus.BCD2        = r_bcd2;
  assign bus.BCD1        = r_bcd1;
  assign bus.BCD0        = r_bcd0;

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Directed bench for vend_txn_ctrl with hand-computed expectations.
module tb_vend_txn_ctrl;

  logic clk;
  logic rst;
  int   nvec;
  int   nmis;
  logic [15:0] w_bcd;

  vend_txn_ctrl_if bus ();

  vend_txn_ctrl #(
    .PRICE_JUICE (25),
    .PRICE_COFFEE(20),
    .MAX_CREDIT  (100),
    .SHOW_TICKS  (3),
    .ERR_TICKS   (2)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  assign w_bcd = {bus.BCD3, bus.BCD2, bus.BCD1, bus.BCD0};

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [1:0] v);
    bus.coin_in  = 1'b1;
    bus.coin_val = v;
    edge1();
    bus.coin_in  = 1'b0;
    bus.coin_val = 2'b00;
  endtask

  task automatic tk();
    bus.tick = 1'b1;
    edge1();
    bus.tick = 1'b0;
  endtask

  task automatic sel_j();
    bus.sel_juice = 1'b1;
    edge1();
    bus.sel_juice = 1'b0;
  endtask

  task automatic sel_c();
    bus.sel_coffee = 1'b1;
    edge1();
    bus.sel_coffee = 1'b0;
  endtask

  initial begin
    nvec = 0;
    nmis = 0;
    rst  = 1'b1;
    bus.tick = 1'b0; bus.coin_in = 1'b0; bus.coin_val = 2'b00;
    bus.sel_juice = 1'b0; bus.sel_coffee = 1'b0; bus.cancel = 1'b0;
    repeat (2) edge1();

    // Reset state
    chk("rst_credit", 16'(bus.credit), 16'd0);
    chk("rst_busy", 16'(bus.busy), 16'd0);
    chk("rst_strobes", 16'({bus.drop_juice, bus.drop_coffee, bus.coin_out, bus.coin_reject}), 16'd0);
    chk("rst_bcd", w_bcd, 16'hF000);
    rst = 1'b0;
    edge1();

    // Three 10-coins then juice
    coin(2'b01); chk("c10_a", 16'(bus.credit), 16'd10);
    coin(2'b01); chk("c10_b", 16'(bus.credit), 16'd20);
    coin(2'b01); chk("c10_c", 16'(bus.credit), 16'd30);
    edge1();     chk("bcd_30", w_bcd, 16'hF030);
    sel_j();
    chk("drop_j", 16'(bus.drop_juice), 16'd1);
    chk("cred_after_j", 16'(bus.credit), 16'd5);
    chk("busy_show", 16'(bus.busy), 16'd1);
    edge1();
    chk("drop_j_one", 16'(bus.drop_juice), 16'd0);
    chk("bcd_juic", w_bcd, 16'hABCD);

    // Events during SHOW
    coin(2'b00);
    chk("show_rej", 16'(bus.coin_reject), 16'd1);
    chk("show_cred", 16'(bus.credit), 16'd5);
    sel_c();
    chk("show_nodrop", 16'(bus.drop_coffee), 16'd0);
    chk("show_cred2", 16'(bus.credit), 16'd5);
    tk(); tk();
    chk("show_busy", 16'(bus.busy), 16'd1);
    tk();
    chk("show_end_nocoin", 16'(bus.coin_out), 16'd0);
    chk("change_busy", 16'(bus.busy), 16'd1);
    chk("change_cred", 16'(bus.credit), 16'd5);
    edge1();
    chk("bcd_005", w_bcd, 16'hF005);
    tk();
    chk("chg_coin", 16'(bus.coin_out), 16'd1);
    chk("chg_cred0", 16'(bus.credit), 16'd0);
    chk("chg_idle", 16'(bus.busy), 16'd0);
    edge1();
    chk("chg_coin_one", 16'(bus.coin_out), 16'd0);
    chk("bcd_000", w_bcd, 16'hF000);

    // Insufficient credit error display
    coin(2'b01); coin(2'b00);
    chk("cred15", 16'(bus.credit), 16'd15);
    sel_c();
    chk("err_nodrop", 16'(bus.drop_coffee), 16'd0);
    chk("err_cred", 16'(bus.credit), 16'd15);
    chk("err_busy", 16'(bus.busy), 16'd0);
    edge1(); chk("err_bcd", w_bcd, 16'hF020);
    tk();
    edge1(); chk("err_bcd_t1", w_bcd, 16'hF020);
    tk();
    edge1(); chk("err_clear", w_bcd, 16'hF015);
    sel_j();
    chk("err_j_nodrop", 16'(bus.drop_juice), 16'd0);
    edge1(); chk("err_bcd_j", w_bcd, 16'hF025);
    coin(2'b00);
    chk("err_coin_cred", 16'(bus.credit), 16'd20);
    edge1(); chk("err_coin_clr", w_bcd, 16'hF020);

    // Exact-price coffee vend leaving zero credit
    sel_c();
    chk("drop_c", 16'(bus.drop_coffee), 16'd1);
    chk("cred_c0", 16'(bus.credit), 16'd0);
    edge1(); chk("bcd_c0ff", w_bcd, 16'hD0EE);
    tk(); tk(); tk();
    chk("show_to_idle", 16'(bus.busy), 16'd0);
    chk("show_to_idle_nc", 16'(bus.coin_out), 16'd0);
    edge1(); chk("bcd_idle", w_bcd, 16'hF000);

    // Credit ceiling and invalid coin
    coin(2'b10); coin(2'b01); coin(2'b01); coin(2'b01); coin(2'b01); coin(2'b00);
    chk("cred95", 16'(bus.credit), 16'd95);
    coin(2'b01);
    chk("over_rej", 16'(bus.coin_reject), 16'd1);
    chk("over_cred", 16'(bus.credit), 16'd95);
    coin(2'b00);
    chk("max_norej", 16'(bus.coin_reject), 16'd0);
    chk("max_cred", 16'(bus.credit), 16'd100);
    edge1(); chk("bcd_100", w_bcd, 16'hF100);
    coin(2'b11);
    chk("inval_rej", 16'(bus.coin_reject), 16'd1);
    chk("inval_cred", 16'(bus.credit), 16'd100);

    // Cancel, partial payout, then asynchronous reset mid-CHANGE
    bus.cancel = 1'b1; edge1(); bus.cancel = 1'b0;
    chk("cancel_busy", 16'(bus.busy), 16'd1);
    repeat (17) tk();
    chk("chg_cred15", 16'(bus.credit), 16'd15);
    rst = 1'b1;
    #2;
    chk("arst_cred", 16'(bus.credit), 16'd0);
    chk("arst_busy", 16'(bus.busy), 16'd0);
    chk("arst_bcd", w_bcd, 16'hF000);
    edge1();
    rst = 1'b0;
    tk(); chk("post_rst_nc1", 16'(bus.coin_out), 16'd0);
    tk(); chk("post_rst_nc2", 16'(bus.coin_out), 16'd0);

    // Cancel + selection + coin together at credit 40
    coin(2'b01); coin(2'b01); coin(2'b01); coin(2'b01);
    chk("cred40", 16'(bus.credit), 16'd40);
    bus.cancel = 1'b1; bus.sel_juice = 1'b1; bus.coin_in = 1'b1; bus.coin_val = 2'b00;
    edge1();
    bus.cancel = 1'b0; bus.sel_juice = 1'b0; bus.coin_in = 1'b0;
    chk("prio_rej", 16'(bus.coin_reject), 16'd1);
    chk("prio_nodrop", 16'(bus.drop_juice), 16'd0);
    chk("prio_cred", 16'(bus.credit), 16'd40);
    chk("prio_busy", 16'(bus.busy), 16'd1);
    for (int k = 1; k <= 8; k++) begin
      tk();
      chk("pay_coin", 16'(bus.coin_out), 16'd1);
      chk("pay_cred", 16'(bus.credit), 16'(40 - 5 * k));
    end
    chk("pay_idle", 16'(bus.busy), 16'd0);
    tk();
    chk("pay_done", 16'(bus.coin_out), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
